tmds_decode: RTL

Receive-side counterpart of the TMDS channel encoder. Takes one 10-bit TMDS character per pixel clock from the channel deserializer and achieves word alignment by requesting bit-slips until control tokens decode cleanly. It then recovers the 8-bit pixel data, the {C1,C0} control pair and data_enable. One instance sits per TMDS channel, between the deserializer and the pixel/sync recovery logic.

---
 rtl/tmds_pkg.sv | 39 +++
 rtl/tmds_word_decode.sv | 21 ++
 rtl/tmds_decode.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, alignment FSM states and token matcher.
package tmds_pkg;

  localparam int unsigned WORD_W = 10;
  localparam int unsigned BYTE_W = 8;

  localparam logic [WORD_W-1:0] CTRL_00 = 10'b1101010100;
  localparam logic [WORD_W-1:0] CTRL_01 = 10'b0010101011;
  localparam logic [WORD_W-1:0] CTRL_10 = 10'b0101010100;
  localparam logic [WORD_W-1:0] CTRL_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } tmds_state_e;

  typedef struct packed {
    logic       match;
    logic [1:0] ctrl;
  } token_t;

  // Exact 10-bit compare against the four control tokens.
  function automatic token_t token_decode(input logic [WORD_W-1:0] word);
    token_t t;
    t.match = 1'b1;
    t.ctrl  = 2'b00;
    case (word)
      CTRL_00: t.ctrl = 2'b00;
      CTRL_01: t.ctrl = 2'b01;
      CTRL_10: t.ctrl = 2'b10;
      CTRL_11: t.ctrl = 2'b11;
      default: t.match = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational TMDS data-character decode: 10-bit transition-minimised word to pixel byte.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] data_c
);

  logic [BYTE_W-1:0] v;

  // Undo optional inversion, then undo the XOR/XNOR chain selected by bit 8.
  always_comb begin
    v      = word[9] ? ~word[BYTE_W-1:0] : word[BYTE_W-1:0];
    data_c = '0;
    data_c[0] = v[0];
    for (int i = 1; i < int'(BYTE_W); i++) begin
      data_c[i] = word[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decode.sv
// TMDS channel receiver: bit-slip word alignment on control tokens plus pixel/control recovery.
module tmds_decode
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS = 8,
  parameter int unsigned SEARCH_WIN  = 4096,
  parameter int unsigned SLIP_WAIT   = 16,
  parameter int unsigned LOSS_WIN    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] tmds_in,
  output logic [BYTE_W-1:0] data_out,
  output logic [1:0]        control,
  output logic              data_enable,
  output logic              aligned,
  output logic              bitslip,
  output logic              token_err
);

  localparam int unsigned MAX_AB  = (SEARCH_WIN > LOSS_WIN) ? SEARCH_WIN : LOSS_WIN;
  localparam int unsigned MAX_CD  = (SLIP_WAIT > LOCK_TOKENS) ? SLIP_WAIT : LOCK_TOKENS;
  localparam int unsigned MAX_WIN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = $clog2(MAX_WIN + 1);
  // Shortest legitimate blanking run; anything shorter while locked is an error.
  localparam int unsigned MIN_BLANK = 4;
  localparam int unsigned RUN_W     = $clog2(MIN_BLANK + 1);

  localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_WIN - 1);
  localparam logic [CNT_W-1:0] SLIP_LAST   = CNT_W'(SLIP_WAIT - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_WIN - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TOKENS - 1);
  localparam logic [RUN_W-1:0] BLANK_SAT   = RUN_W'(MIN_BLANK);

  token_t            tok_c;
  logic [WORD_W-1:0] s1_word;
  token_t            s1_tok;
  logic [BYTE_W-1:0] dec_c;

  tmds_state_e       state, state_nx;
  logic [CNT_W-1:0]  win_cnt, win_nx;
  logic [CNT_W-1:0]  run_cnt, run_nx;
  logic [CNT_W-1:0]  wait_cnt, wait_nx;
  logic [CNT_W-1:0]  loss_cnt, loss_nx;
  logic [RUN_W-1:0]  blank_cnt, blank_nx;
  logic              aligned_nx, bitslip_nx, token_err_nx;

  assign tok_c = token_decode(tmds_in);

  // Stage 1: capture the word and its token classification.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_word <= '0;
      s1_tok  <= '0;
    end else begin
      s1_word <= tmds_in;
      s1_tok  <= tok_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      win_cnt   <= '0;
      run_cnt   <= '0;
      wait_cnt  <= '0;
      loss_cnt  <= '0;
      blank_cnt <= '0;
      aligned   <= 1'b0;
      bitslip   <= 1'b0;
      token_err <= 1'b0;
    end else begin
      state     <= state_nx;
      win_cnt   <= win_nx;
      run_cnt   <= run_nx;
      wait_cnt  <= wait_nx;
      loss_cnt  <= loss_nx;
      blank_cnt <= blank_nx;
      aligned   <= aligned_nx;
      bitslip   <= bitslip_nx;
      token_err <= token_err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    win_nx       = win_cnt;
    run_nx       = run_cnt;
    wait_nx      = wait_cnt;
    loss_nx      = loss_cnt;
    blank_nx     = blank_cnt;
    aligned_nx   = aligned;
    bitslip_nx   = 1'b0;
    token_err_nx = 1'b0;
    case (state)
      SEARCH: begin
        if (s1_tok.match) begin
          run_nx   = CNT_W'(1);
          state_nx = CHECK;
        end else if (win_cnt == SEARCH_LAST) begin
          bitslip_nx = 1'b1;
          win_nx     = '0;
          wait_nx    = '0;
          state_nx   = SLIP;
        end else begin
          win_nx = win_cnt + CNT_W'(1);
        end
      end
      SLIP: begin
        if (wait_cnt == SLIP_LAST) begin
          wait_nx  = '0;
          state_nx = SEARCH;
        end else begin
          wait_nx = wait_cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (s1_tok.match) begin
          if (run_cnt == LOCK_LAST) begin
            state_nx   = LOCKED;
            aligned_nx = 1'b1;
            run_nx     = '0;
            loss_nx    = '0;
            win_nx     = '0;
            blank_nx   = BLANK_SAT;
          end else begin
            run_nx = run_cnt + CNT_W'(1);
          end
        end else begin
          // win_cnt is left untouched so slip cadence is not restarted.
          run_nx   = '0;
          state_nx = SEARCH;
        end
      end
      LOCKED: begin
        if (s1_tok.match) begin
          loss_nx = '0;
          if (blank_cnt != BLANK_SAT) blank_nx = blank_cnt + RUN_W'(1);
        end else begin
          if ((blank_cnt != '0) && (blank_cnt < BLANK_SAT)) token_err_nx = 1'b1;
          blank_nx = '0;
          if (loss_cnt == LOSS_LAST) begin
            loss_nx    = '0;
            aligned_nx = 1'b0;
            state_nx   = SEARCH;
          end else begin
            loss_nx = loss_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  tmds_word_decode u_word_decode (
    .word   (s1_word),
    .data_c (dec_c)
  );

  // Stage 2: outputs are qualified by lock; control holds across data periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out    <= '0;
      control     <= 2'b00;
      data_enable <= 1'b0;
    end else if (state != LOCKED) begin
      data_out    <= '0;
      control     <= 2'b00;
      data_enable <= 1'b0;
    end else if (s1_tok.match) begin
      control     <= s1_tok.ctrl;
      data_enable <= 1'b0;
    end else begin
      data_out    <= dec_c;
      data_enable <= 1'b1;
    end
  end

endmodule
